// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit: 32-iteration shift-add multiply and restoring divide,
// with sign correction applied in a final FIX cycle before HI/LO are written.
module hilo_muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wr_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e      r_state, w_state_next;
  logic [1:0]  r_op, w_op_next;
  logic [31:0] r_m, w_m_next;
  logic [63:0] r_acc, w_acc_next;
  logic [4:0]  r_cnt, w_cnt_next;
  logic        r_neg_res, w_neg_res_next;
  logic        r_neg_rem, w_neg_rem_next;
  logic        r_div_zero, w_div_zero_next;
  logic [31:0] r_raw_a, w_raw_a_next;
  logic [31:0] r_hi, w_hi_next;
  logic [31:0] r_lo, w_lo_next;
  logic        r_done, w_done_next;

  logic        w_a_neg, w_b_neg;
  logic [31:0] w_abs_a, w_abs_b;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_step;
  logic [32:0] w_rem_sh;
  logic        w_rem_ge;
  logic [31:0] w_rem_diff;
  logic [63:0] w_div_step;
  logic [63:0] w_prod_fix;
  logic [31:0] w_quot_fix, w_rem_fix;

  always_comb begin
    w_a_neg = ~op[0] & rs_val[31];
    w_b_neg = ~op[0] & rt_val[31];
    w_abs_a = w_a_neg ? (~rs_val + 32'd1) : rs_val;
    w_abs_b = w_b_neg ? (~rt_val + 32'd1) : rt_val;

    // Multiply: upper half accumulates, multiplier shifts out of the lower half.
    w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_m} : 33'd0);
    w_mul_step = {w_mul_sum, r_acc[31:1]};

    // Divide: remainder in the upper half, quotient bits shift into the lower half.
    w_rem_sh   = r_acc[63:31];
    w_rem_ge   = (w_rem_sh >= {1'b0, r_m});
    w_rem_diff = w_rem_sh[31:0] - r_m;
    w_div_step = w_rem_ge ? {w_rem_diff, r_acc[30:0], 1'b1}
                          : {w_rem_sh[31:0], r_acc[30:0], 1'b0};

    w_prod_fix = r_neg_res ? (~r_acc + 64'd1) : r_acc;
    w_quot_fix = r_neg_res ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
    w_rem_fix  = r_neg_rem ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
  end

  always_comb begin
    w_state_next    = r_state;
    w_op_next       = r_op;
    w_m_next        = r_m;
    w_acc_next      = r_acc;
    w_cnt_next      = r_cnt;
    w_neg_res_next  = r_neg_res;
    w_neg_rem_next  = r_neg_rem;
    w_div_zero_next = r_div_zero;
    w_raw_a_next    = r_raw_a;
    w_hi_next       = r_hi;
    w_lo_next       = r_lo;
    w_done_next     = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_op_next       = op;
          w_m_next        = op[1] ? w_abs_b : w_abs_a;
          w_acc_next      = {32'd0, op[1] ? w_abs_a : w_abs_b};
          w_neg_res_next  = w_a_neg ^ w_b_neg;
          w_neg_rem_next  = w_a_neg;
          w_div_zero_next = op[1] & (rt_val == 32'd0);
          w_raw_a_next    = rs_val;
          w_cnt_next      = 5'd0;
          w_state_next    = StCalc;
        end else begin
          if (mthi) w_hi_next = wr_data;
          if (mtlo) w_lo_next = wr_data;
        end
      end
      StCalc: begin
        w_acc_next = r_op[1] ? w_div_step : w_mul_step;
        w_cnt_next = r_cnt + 5'd1;
        if (r_cnt == 5'd31) w_state_next = StFix;
      end
      StFix: begin
        if (!r_op[1]) begin
          w_hi_next = w_prod_fix[63:32];
          w_lo_next = w_prod_fix[31:0];
        end else if (r_div_zero) begin
          w_hi_next = r_raw_a;
          w_lo_next = 32'hFFFF_FFFF;
        end else begin
          w_hi_next = w_rem_fix;
          w_lo_next = w_quot_fix;
        end
        w_done_next  = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_op       <= 2'd0;
      r_m        <= 32'd0;
      r_acc      <= 64'd0;
      r_cnt      <= 5'd0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_div_zero <= 1'b0;
      r_raw_a    <= 32'd0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_op       <= w_op_next;
      r_m        <= w_m_next;
      r_acc      <= w_acc_next;
      r_cnt      <= w_cnt_next;
      r_neg_res  <= w_neg_res_next;
      r_neg_rem  <= w_neg_rem_next;
      r_div_zero <= w_div_zero_next;
      r_raw_a    <= w_raw_a_next;
      r_hi       <= w_hi_next;
      r_lo       <= w_lo_next;
      r_done     <= w_done_next;
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = (r_state != StIdle);
  assign done = r_done;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed vector table, random ops against an
// arithmetic reference model, and hand sequences for MT writes and mid-operation reset.
module tb_hilo_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wr_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  hilo_muldiv_unit dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .wr_data (wr_data),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic set_vec(input int i, input string name, input logic [1:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el);
    vecs[i].name = name;
    vecs[i].op   = o;
    vecs[i].a    = a;
    vecs[i].b    = b;
    vecs[i].hi   = eh;
    vecs[i].lo   = el;
  endtask

  // Reference: plain 64-bit arithmetic; SV signed / and % truncate toward zero.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] mh, output logic [31:0] ml);
    longint      sa, sb, sp, sq, sr;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    mh = 32'd0;
    ml = 32'd0;
    case (o)
      2'd0: begin
        sp = sa * sb;
        mh = sp[63:32];
        ml = sp[31:0];
      end
      2'd1: begin
        up = {32'd0, a} * {32'd0, b};
        mh = up[63:32];
        ml = up[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          mh = a;
          ml = 32'hFFFF_FFFF;
        end else if (o == 2'd2) begin
          sq = sa / sb;
          sr = sa % sb;
          mh = sr[31:0];
          ml = sq[31:0];
        end else begin
          mh = a % b;
          ml = a / b;
        end
      end
    endcase
  endfunction

  // Returns at the falling edge just after the start edge; operands are then scrambled.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    @(negedge clk);
    start  = 1'b0;
    op     = 2'($urandom_range(0, 3));
    rs_val = $urandom;
    rt_val = $urandom;
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int          busy_cnt;
    int          done_cnt;
    int          done_k;
    logic        held;
    logic [31:0] hi0, lo0, got_hi, got_lo;
    busy_cnt = 0;
    done_cnt = 0;
    done_k   = -1;
    held     = 1'b1;
    got_hi   = 32'd0;
    got_lo   = 32'd0;
    hi0      = hi;
    lo0      = lo;
    launch(o, a, b);
    for (int k = 0; k <= 36; k++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_k < 0) begin
          done_k = k;
          got_hi = hi;
          got_lo = lo;
        end
      end
      if (k <= 32 && (hi !== hi0 || lo !== lo0)) held = 1'b0;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
    check({name, "_done_at"}, 64'(done_k), 64'd33);
    check({name, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check({name, "_hilo_held"}, 64'(held), 64'd1);
    check({name, "_hi"}, 64'(got_hi), 64'(eh));
    check({name, "_lo"}, 64'(got_lo), 64'(el));
  endtask

  task automatic finish_op(input string name, input logic [31:0] eh, input logic [31:0] el);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 45 && !seen; k++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    check({name, "_done_seen"}, 64'(seen), 64'd1);
    check({name, "_hi"}, 64'(hi), 64'(eh));
    check({name, "_lo"}, 64'(lo), 64'(el));
    @(negedge clk);
    check({name, "_done_low"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [31:0] mh, ml, a, b, lo_before, hi_before;
    logic [1:0]  o;
    int          done_seen;

    set_vec(0, "multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    set_vec(1, "mult_m3x7", 2'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    set_vec(2, "div_m7d2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    set_vec(3, "divu_100d7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14);
    set_vec(4, "div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    set_vec(5, "divu_zero", 2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    set_vec(6, "div_zero_neg", 2'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    set_vec(7, "mult_min", 2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0);
    set_vec(8, "div_7dm2", 2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    set_vec(9, "mult_m1xm1", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1);

    // Reset with start and MT requests pending: reset wins.
    reset   = 1'b1;
    start   = 1'b1;
    op      = 2'd1;
    rs_val  = 32'd9;
    rt_val  = 32'd9;
    mthi    = 1'b1;
    mtlo    = 1'b1;
    wr_data = 32'hCAFE_F00D;
    repeat (3) @(negedge clk);
    start = 1'b0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'($urandom_range(0, 15));
        1: a = 32'h8000_0000;
        2: b = 32'd0;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      model(o, a, b, mh, ml);
      run_op("rand", o, a, b, mh, ml);
    end

    // MT writes in IDLE, singly and together.
    @(negedge clk);
    mthi    = 1'b1;
    wr_data = 32'h0000_1234;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_idle", 64'(hi), 64'h1234);
    mthi    = 1'b1;
    mtlo    = 1'b1;
    wr_data = 32'h0000_ABCD;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    check("mt_both_hi", 64'(hi), 64'hABCD);
    check("mt_both_lo", 64'(lo), 64'hABCD);

    // MTLO while busy is dropped.
    launch(2'd3, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    lo_before = lo;
    mtlo      = 1'b1;
    wr_data   = 32'hDEAD_BEEF;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo_busy_ignored", 64'(lo), 64'(lo_before));
    finish_op("mtlo_busy", 32'd2, 32'd14);

    // start and MTHI in the same cycle: only the result lands.
    hi_before = hi;
    @(negedge clk);
    start   = 1'b1;
    op      = 2'd1;
    rs_val  = 32'd3;
    rt_val  = 32'd5;
    mthi    = 1'b1;
    wr_data = 32'h5555_5555;
    @(negedge clk);
    start = 1'b0;
    mthi  = 1'b0;
    check("start_mthi_dropped", 64'(hi), 64'(hi_before));
    finish_op("start_mthi", 32'd0, 32'd15);

    // Reset at iteration 10 discards the operation.
    @(negedge clk);
    mthi    = 1'b1;
    mtlo    = 1'b1;
    wr_data = 32'h7777_0001;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    launch(2'd1, 32'hFFFF_FFFF, 32'd2);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_hi", 64'(hi), 64'd0);
    check("midreset_lo", 64'(lo), 64'd0);
    check("midreset_busy", 64'(busy), 64'd0);
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) done_seen++;
      if (hi !== 32'd0 || lo !== 32'd0) done_seen += 100;
      @(negedge clk);
    end
    check("midreset_no_done", 64'(done_seen), 64'd0);
    run_op("after_reset", 2'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
HILO_MULDIV_UNIT -- requirements
Module: hilo_muldiv_unit

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset.
REQ-002 SHALL provide port `clk`, input, 1 bit: rising-edge clock.
REQ-003 SHALL provide port `reset`, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL provide port `start`, input, 1 bit: launch an operation; sampled only in IDLE.
REQ-005 SHALL provide port `op`, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL provide port `rs_val`, input, 32 bits: operand A, the multiplicand or dividend.
REQ-007 SHALL provide port `rt_val`, input, 32 bits: operand B, the multiplier or divisor.
REQ-008 SHALL provide port `mthi`, input, 1 bit: write `wr_data` into HI.
REQ-009 SHALL provide port `mtlo`, input, 1 bit: write `wr_data` into LO.
REQ-010 SHALL provide port `wr_data`, input, 32 bits: data for MTHI/MTLO.
REQ-011 SHALL provide port `hi`, output, 32 bits: HI register, which feeds the downstream HI select.
REQ-012 SHALL provide port `lo`, output, 32 bits: LO register, which feeds the downstream LO select.
REQ-013 SHALL provide port `busy`, output, 1 bit: operation in progress; the pipeline stalls on MFHI/MFLO while it is high.
REQ-014 SHALL provide port `done`, output, 1 bit: one-cycle pulse when HI/LO take a new result.

Function
REQ-015 SHALL implement the states IDLE, CALC and FIX as a registered state machine.
REQ-016 SHALL, in IDLE with `start`=1 at edge N:
- latch `op`;
- latch |A| and |B| (signed ops) or raw A and B (unsigned ops);
- latch the result sign flags;
- clear the 5-bit iteration counter;
- go to CALC.
REQ-017 SHALL perform one iteration per edge in CALC (edges N+1..N+32), incrementing the counter, and go to FIX at the edge where the counter is 31.
REQ-018 SHALL, for multiply, perform shift-add over a 64-bit accumulator, one multiplier bit per iteration, LSB first.
REQ-019 SHALL, for divide, perform restoring shift-subtract over a 64-bit remainder:quotient pair, one quotient bit per iteration, MSB first.
REQ-020 SHALL, at FIX (edge N+33):
- apply the sign correction;
- write HI and LO;
- assert `done` for exactly the following cycle;
- return to IDLE.
REQ-021 SHALL, for MULT with operand signs differing, write the two's complement of the full 64-bit product; HI SHALL be bits 63:32 and LO bits 31:0.
REQ-022 SHALL, for DIV, negate the quotient when operand signs differ, give the remainder the sign of the dividend, write LO as the quotient and HI as the remainder.
REQ-023 SHALL, for signed overflow (0x80000000 / -1), produce LO=0x80000000 and HI=0x00000000.
REQ-024 SHALL, for divide by zero (B=0, DIV or DIVU), still take the full latency and produce LO=0xFFFFFFFF and HI=raw `rs_val`.
REQ-025 SHALL drive `busy`=1 in every cycle following edges N..N+32 and `busy`=0 otherwise.
REQ-026 SHALL hold `hi` and `lo` at their previous values throughout CALC and never expose partial results.
REQ-027 SHALL ignore `start` while not in IDLE, with no queuing.
REQ-028 SHALL, in IDLE without `start`, write `wr_data` to HI when `mthi`=1 and to LO when `mtlo`=1; if both are asserted, both registers SHALL be written.
REQ-029 SHALL give `start` priority over `mthi`/`mtlo` in the same IDLE cycle; the MT writes SHALL be dropped.
REQ-030 SHALL ignore `mthi`/`mtlo` while busy or in FIX.
REQ-031 SHALL ignore operand and `op` changes after edge N.

Reset
REQ-032 SHALL, when `reset`=1 at a rising edge, force state IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0 and counter=0, regardless of state.
REQ-033 SHALL, on reset mid-operation, discard the operation: no `done` pulse and no HI/LO update afterwards.
REQ-034 SHALL give reset priority over `start`, `mthi` and `mtlo`.

Verification
REQ-035 SHALL cover MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; `done` pulses 33 edges after start; `busy` high for 33 cycles.
REQ-036 SHALL cover MULT -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-037 SHALL cover DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, and DIVU 100 / 7 -> LO=14, HI=2.
REQ-038 SHALL cover DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, and DIVU 5 / 0 -> LO=0xFFFFFFFF, HI=5.
REQ-039 SHALL cover MTHI 0x1234 in IDLE -> `hi`=0x1234 next cycle; MTLO during busy -> `lo` unchanged; `start`+`mthi` together -> only the operation result lands.
REQ-040 SHALL cover `reset` asserted at iteration 10 -> `hi`=`lo`=0 and `busy`=0 next cycle, no `done` pulse; a new `start` afterwards completes normally.
